// File: rtl/fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory req/ack port, redirect input,
// IF/OF latch valid/ready port and halt status.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        of_ready;
  logic        halted;

  // Fetch-unit side
  modport master (
    output imem_req, imem_addr, if_valid, if_pc, if_instr, halted,
    input  imem_ack, imem_rdata, redirect, redirect_pc, of_ready
  );

  // Environment side: memory, execute redirect, operand-fetch stage
  modport slave (
    input  imem_req, imem_addr, if_valid, if_pc, if_instr, halted,
    output imem_ack, imem_rdata, redirect, redirect_pc, of_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: program counter, a single outstanding req/ack
// fetch to instruction memory, and a one-entry IF/OF latch. Redirects from
// execute win over everything; a fetched hlt stops fetching until redirect.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master bus
);
  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

  localparam logic [4:0] OPC_HLT = 5'b11111;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] hold_addr_reg, hold_addr_next;
  logic        pending_reg, pending_next;
  logic        squash_reg, squash_next;
  logic        if_valid_reg, if_valid_next;
  logic [31:0] if_pc_reg, if_pc_next;
  logic [31:0] if_instr_reg, if_instr_next;

  logic        req;
  logic        ack_seen;
  logic        capture;
  logic        drain;

  // An outstanding request is always held; a new one starts only while
  // running and when the latch is empty or being emptied this cycle.
  // Gated by rst so the request drops the moment reset is asserted.
  assign req      = !rst && (pending_reg ||
                             (state_reg == RUN && (!if_valid_reg || bus.of_ready)));
  assign ack_seen = req && bus.imem_ack;
  assign capture  = ack_seen && !squash_reg && !bus.redirect;
  assign drain    = if_valid_reg && bus.of_ready;

  // While a squashed request is still in flight, pc already holds the
  // redirect target, so the memory keeps seeing the old address instead.
  assign bus.imem_req  = req;
  assign bus.imem_addr = squash_reg ? hold_addr_reg : pc_reg;
  assign bus.if_valid  = if_valid_reg;
  assign bus.if_pc     = if_pc_reg;
  assign bus.if_instr  = if_instr_reg;
  assign bus.halted    = (state_reg == HALT);

  // Next-state logic: redirect first, then capture/drain/halt.
  always_comb begin
    state_next     = state_reg;
    pc_next        = pc_reg;
    hold_addr_next = hold_addr_reg;
    pending_next   = req && !bus.imem_ack;
    squash_next    = squash_reg && !ack_seen;
    if_valid_next  = if_valid_reg;
    if_pc_next     = if_pc_reg;
    if_instr_next  = if_instr_reg;

    if (bus.redirect) begin
      pc_next       = bus.redirect_pc;
      if_valid_next = 1'b0;
      state_next    = RUN;
      // An unacked request in flight must have its data thrown away later.
      squash_next   = req && !bus.imem_ack;
      if (req && !bus.imem_ack) begin
        hold_addr_next = bus.imem_addr;
      end
    end else begin
      if (drain) begin
        if_valid_next = 1'b0;
      end
      if (capture) begin
        if_valid_next = 1'b1;
        if_pc_next    = pc_reg;
        if_instr_next = bus.imem_rdata;
        pc_next       = pc_reg + 32'd4;
        if (bus.imem_rdata[31:27] == OPC_HLT) begin
          state_next = HALT;
        end
      end
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= RUN;
      pc_reg        <= RESET_PC;
      hold_addr_reg <= 32'd0;
      pending_reg   <= 1'b0;
      squash_reg    <= 1'b0;
      if_valid_reg  <= 1'b0;
      if_pc_reg     <= 32'd0;
      if_instr_reg  <= 32'd0;
    end else begin
      state_reg     <= state_next;
      pc_reg        <= pc_next;
      hold_addr_reg <= hold_addr_next;
      pending_reg   <= pending_next;
      squash_reg    <= squash_next;
      if_valid_reg  <= if_valid_next;
      if_pc_reg     <= if_pc_next;
      if_instr_reg  <= if_instr_next;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed scenarios plus randomized latency,
// backpressure and redirects, checked against an in-order instruction
// stream model (next expected pc, word from a memory function).
module tb_fetch_unit;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rst_w = 1'b0;

  always #5 clk = ~clk;

  fetch_unit_if bus();
  fetch_unit_if bus_w();

  fetch_unit u_dut (.clk(clk), .rst(rst), .bus(bus));
  fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (.clk(clk), .rst(rst_w), .bus(bus_w));

  int n_tests = 0;
  int n_fail  = 0;

  // Memory model state
  logic        halt_en   = 1'b0;
  logic [31:0] halt_addr = 32'd0;
  logic        mem_busy  = 1'b0;
  logic [31:0] mem_addr  = 32'd0;
  int          mem_wait  = 0;
  int          lat       = 0;
  logic        rand_lat  = 1'b0;

  // Stream model state
  logic [31:0] exp_pc     = 32'd0;
  logic        stream_end = 1'b0;

  // Pre-edge observations of the most recent cycle
  logic        obs_req, obs_valid, obs_halted;
  logic [31:0] obs_addr, obs_pc;

  logic [31:0] req_log[$];
  logic [31:0] cons_log[$];
  logic [31:0] wrap_log[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] memword(input logic [31:0] a);
    if (halt_en && a == halt_addr) return 32'hF800_0000;
    return {1'b0, a[30:0] ^ 31'h2A5C_3B17};
  endfunction

  // One clock cycle on the main DUT, starting just after a falling edge.
  task automatic cycle(input logic rdy, input logic rd, input logic [31:0] rpc);
    logic        consume;
    logic [31:0] w;
    bus.of_ready    = rdy;
    bus.redirect    = rd;
    bus.redirect_pc = rpc;
    bus.imem_ack    = 1'b0;
    #1;
    obs_req    = bus.imem_req;
    obs_addr   = bus.imem_addr;
    obs_valid  = bus.if_valid;
    obs_pc     = bus.if_pc;
    obs_halted = bus.halted;
    if (obs_req) begin
      if (!mem_busy) begin
        mem_busy = 1'b1;
        mem_addr = obs_addr;
        mem_wait = rand_lat ? int'($urandom_range(0, 3)) : lat;
        req_log.push_back(obs_addr);
      end else begin
        check("addr_stable", obs_addr, mem_addr);
      end
      if (mem_wait == 0) begin
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = memword(mem_addr);
      end
    end else if (mem_busy) begin
      check("req_held", 32'(obs_req), 32'd1);
    end
    #1;
    if (stream_end && !rd) begin
      check("halted_hold", 32'(obs_halted), 32'd1);
      check("no_req_halted", 32'(obs_req), 32'd0);
    end
    consume = obs_valid && rdy && !rd;
    if (consume) begin
      $display("[TB] deliver pc=%h instr=%h", bus.if_pc, bus.if_instr);
      cons_log.push_back(bus.if_pc);
      if (stream_end) begin
        check("after_halt", 32'(obs_valid), 32'd0);
      end else begin
        w = memword(exp_pc);
        check("if_pc", bus.if_pc, exp_pc);
        check("if_instr", bus.if_instr, w);
        if (w[31:27] == 5'b11111) begin
          stream_end = 1'b1;
          check("halted_on_hlt", 32'(obs_halted), 32'd1);
          check("no_req_on_hlt", 32'(obs_req), 32'd0);
        end else begin
          exp_pc = exp_pc + 32'd4;
        end
      end
    end
    if (rd) begin
      $display("[TB] redirect to %h", rpc);
      exp_pc     = rpc;
      stream_end = 1'b0;
    end
    @(posedge clk);
    #1;
    if (bus.imem_ack) mem_busy = 1'b0;
    else if (mem_busy) mem_wait--;
    @(negedge clk);
  endtask

  // Assert reset (asynchronously), hold with random inputs, release.
  task automatic do_reset(input int cycles);
    rst = 1'b1;
    #1;
    check("rst_req", 32'(bus.imem_req), 32'd0);
    check("rst_valid", 32'(bus.if_valid), 32'd0);
    check("rst_if_pc", bus.if_pc, 32'd0);
    check("rst_if_instr", bus.if_instr, 32'd0);
    check("rst_halted", 32'(bus.halted), 32'd0);
    mem_busy   = 1'b0;
    exp_pc     = 32'd0;
    stream_end = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      bus.imem_ack    = 1'($urandom);
      bus.imem_rdata  = $urandom;
      bus.of_ready    = 1'($urandom);
      bus.redirect    = 1'($urandom);
      bus.redirect_pc = $urandom;
      @(posedge clk);
      #1;
      check("rst_hold_req", 32'(bus.imem_req), 32'd0);
      check("rst_hold_valid", 32'(bus.if_valid), 32'd0);
    end
    @(negedge clk);
    bus.redirect = 1'b0;
    bus.imem_ack = 1'b0;
    bus.of_ready = 1'b1;
    rst = 1'b0;
    #1;
    $display("[TB] reset released");
    check("restart_req", 32'(bus.imem_req), 32'd1);
    check("restart_addr", bus.imem_addr, 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] wexp[3];
    logic        found;
    logic        rdy, rd;
    logic [31:0] rpc;

    bus.imem_ack = 1'b0; bus.imem_rdata = 32'd0; bus.of_ready = 1'b0;
    bus.redirect = 1'b0; bus.redirect_pc = 32'd0;
    bus_w.imem_ack = 1'b1; bus_w.imem_rdata = 32'd0; bus_w.of_ready = 1'b1;
    bus_w.redirect = 1'b0; bus_w.redirect_pc = 32'd0;
    rst_w = 1'b1;

    // Reset with random inputs, then zero-wait streaming
    do_reset(3);
    lat = 0; rand_lat = 1'b0;
    cons_log.delete();
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 32'd0);
    check("stream_count", 32'(cons_log.size()), 32'd5);

    // Backpressure after the first capture
    do_reset(1);
    cycle(1'b1, 1'b0, 32'd0);
    check("fetch_latency", 32'(bus.if_valid), 32'd1);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 32'd0);
      check("bp_req", 32'(obs_req), 32'd0);
      check("bp_valid", 32'(obs_valid), 32'd1);
      check("bp_pc", obs_pc, 32'd0);
    end
    cycle(1'b1, 1'b0, 32'd0);
    check("bp_next_req", 32'(obs_req), 32'd1);
    check("bp_next_addr", obs_addr, 32'd4);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 32'd0);

    // Redirect while the fetch of addr 8 is waiting on a 2-wait memory
    do_reset(1);
    lat = 2;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cycle(1'b1, 1'b0, 32'd0);
      if (obs_req && obs_addr == 32'd8) found = 1'b1;
    end
    check("saw_addr8", 32'(found), 32'd1);
    req_log.delete();
    cons_log.delete();
    cycle(1'b1, 1'b1, 32'h100);
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 32'd0);
    check("squash_next_req", (req_log.size() > 0) ? req_log[0] : 32'hFFFF_FFFF, 32'h100);
    check("squash_first_pc", (cons_log.size() > 0) ? cons_log[0] : 32'hFFFF_FFFF, 32'h100);

    // Halt at word 3, then redirect out of it
    do_reset(1);
    lat = 0; halt_en = 1'b1; halt_addr = 32'hC;
    cons_log.delete();
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 32'd0);
    check("halt_last_pc", (cons_log.size() > 0) ? cons_log[cons_log.size()-1] : 32'hFFFF_FFFF, 32'hC);
    check("halted", 32'(bus.halted), 32'd1);
    cycle(1'b1, 1'b1, 32'h40);
    cycle(1'b1, 1'b0, 32'd0);
    check("halt_cleared", 32'(obs_halted), 32'd0);
    check("halt_exit_req", 32'(obs_req), 32'd1);
    check("halt_exit_addr", obs_addr, 32'h40);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 32'd0);

    // Reset asserted mid-request with a valid latch
    halt_en = 1'b0;
    do_reset(1);
    lat = 0;
    cycle(1'b1, 1'b0, 32'd0);
    lat = 3;
    bus.of_ready = 1'b1; bus.redirect = 1'b0; bus.imem_ack = 1'b0;
    #1;
    check("mid_pre_req", 32'(bus.imem_req), 32'd1);
    check("mid_pre_valid", 32'(bus.if_valid), 32'd1);
    do_reset(2);
    lat = 0;
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 32'd0);

    // PC wrap on an instance reset to FFFF_FFF8 with zero-wait memory
    wexp[0] = 32'hFFFF_FFF8; wexp[1] = 32'hFFFF_FFFC; wexp[2] = 32'h0000_0000;
    @(negedge clk);
    rst_w = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      bus_w.imem_rdata = memword(bus_w.imem_addr);
      if (i == 0) check("wrap_first_addr", bus_w.imem_addr, 32'hFFFF_FFF8);
      #1;
      if (bus_w.if_valid) begin
        $display("[TB] wrap deliver pc=%h instr=%h", bus_w.if_pc, bus_w.if_instr);
        wrap_log.push_back(bus_w.if_pc);
        check("wrap_instr", bus_w.if_instr, memword(bus_w.if_pc));
      end
      @(negedge clk);
    end
    for (int k = 0; k < 3; k++) begin
      check("wrap_pc", (wrap_log.size() > k) ? wrap_log[k] : 32'hDEAD_BEEF, wexp[k]);
    end

    // Randomized latency, backpressure and redirects with a reachable hlt
    do_reset(1);
    rand_lat = 1'b1; halt_en = 1'b1; halt_addr = 32'h60;
    for (int i = 0; i < 600; i++) begin
      rdy = ($urandom_range(0, 9) < 7);
      rd  = stream_end ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 29) == 0);
      rpc = 32'($urandom_range(0, 31)) * 32'd4;
      cycle(rdy, rd, rpc);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the SimpleRisc core. It holds the program counter and issues word fetches to instruction memory over a req/ack handshake. Fetched instructions land in a one-entry IF/OF latch with a valid/ready handshake. It sits directly upstream of the operand-fetch stage, whose selection muxes consume `if_pc`/`if_instr`, and it accepts branch/return redirects from execute.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset
- `clk` input 1: single clock; all state updates on the rising edge
- `rst` input 1: reset, asynchronous and active-high
- `imem_req` output 1: fetch request; held with a stable address until acked
- `imem_addr` output 32: fetch address, equal to the current PC
- `imem_ack` input 1: memory returns data this cycle; ignored while `imem_req`=0
- `imem_rdata` input 32: instruction word, valid when `imem_ack`=1
- `redirect` input 1: taken branch/call/ret; highest priority
- `redirect_pc` input 32: new PC when `redirect`=1
- `if_valid` output 1: IF/OF latch holds an instruction
- `if_pc` output 32: PC of latched instruction
- `if_instr` output 32: latched instruction
- `of_ready` input 1: downstream accepts the latch this cycle
- `halted` output 1: `hlt` fetched; fetching stopped

## Operation
- State: `pc`[31:0]; `state` ∈ {RUN, HALT}; `pending` (request issued, not yet acked); `squash` (outstanding request's data to be discarded).
- Reset (async): `pc`=RESET_PC, state=RUN, pending=0, squash=0, `if_valid`=0, `if_pc`=0, `if_instr`=0, `halted`=0, `imem_req`=0 while `rst`=1.
- `imem_req` = pending OR (state==RUN AND (!if_valid OR of_ready)). `imem_addr` = pc.
- Once `imem_req` rises, it stays high and `pc` stays frozen until `imem_ack`. Only one request is ever outstanding.
- Drain: if_valid AND of_ready clears `if_valid` unless a capture happens in the same cycle.
- Capture: `imem_req` AND `imem_ack` AND !squash AND !redirect. The unit loads `if_instr`=rdata, `if_pc`=pc, `if_valid`=1, and `pc`=pc+4 (mod 2^32, wraps FFFF_FFFC→0000_0000). This is safe by construction: the slot is empty or draining.
- Discard: ack with squash=1, or ack in the same cycle as redirect. Data is dropped, squash clears, and pc is not incremented.
- Redirect (any state): `pc`=redirect_pc, `if_valid`=0, state=RUN, `halted`=0. If a request is outstanding and not acked this cycle, squash=1 and the old address is held until its ack, then discarded. The first request to redirect_pc issues the cycle after that ack.
- Halt: a capture with opcode `imem_rdata[31:27]`==5'b11111 is still delivered to the latch. state→HALT and `halted`=1 next cycle, and no new requests are issued. Exit only by redirect or reset.
- Redirect has priority over capture, drain and halt in the same cycle.

## Timing
- Zero-wait memory (ack in the same cycle as req) with `of_ready`=1 gives 1 instruction/cycle. The first `imem_req` is in the first cycle after `rst` falls.
- Fetch latency: `if_valid` is high the cycle after the ack edge.
- N-cycle memory: req high N+1 cycles; addr stable throughout.
- `of_ready`=0 with `if_valid`=1 and no pending request: `imem_req`=0 and the latch is held unchanged.
- Redirect→first new `imem_req`: the next cycle if nothing is outstanding, otherwise the cycle after the squashed ack.
- Async reset mid-request: outputs go to reset values immediately. Any later ack from the aborted request is not expected; memory is reset too.

## Test plan
- Reset: hold `rst`=1 with random inputs, then release. Required: all outputs 0 during reset; cycle 1 after release `imem_req`=1 and `imem_addr`=0.
- Streaming: ack every cycle with `of_ready`=1. Required: `if_pc` = 0,4,8,12 on consecutive cycles with `if_instr` matching memory; then set RESET_PC=FFFF_FFF8 and check the PC sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Backpressure: `of_ready`=0 for 3 cycles after the first capture. Required: `if_pc`=0 held, `imem_req`=0. Raise `of_ready`: the next request is for addr 4, with no loss or duplication.
- Squashed redirect: memory acks after 2 wait cycles; assert `redirect` with redirect_pc=0x100 while a fetch of addr 8 is pending. Required: addr stays 8 until ack, that data never appears, the next request is for addr 0x100, and `if_pc`=0x100 follows.
- Halt: word 3 (addr 0xC) = 0xF800_0000. Required: it is delivered with `if_pc`=0xC, `halted`=1 next cycle, and no further `imem_req`. A redirect to 0x40 then clears `halted` and the next request is for 0x40.
- Reset mid-fetch: assert `rst` asynchronously while `imem_req`=1 with ack pending. Required: immediate `imem_req`=0 and `if_valid`=0, and a restart at RESET_PC after release.
